driver_motoare_pwm: RTL and testbench



---
 rtl/driver_motoare_pwm_pkg.sv | 22 ++
 rtl/driver_motoare_pwm_canal_motor.sv | 147 ++++++++++++++
 rtl/driver_motoare_pwm.sv | 56 +++++
 tb/tb_driver_motoare_pwm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/driver_motoare_pwm_pkg.sv
// Shared definitions for the dual-channel H-bridge PWM driver.
package pachet_motoare;

  // Per-channel operating states
  typedef enum logic [1:0] {
    FRANA = 2'd0,  // stopped, bridge off
    PAUZA = 2'd1,  // dead time before a reversal
    RAMPA = 2'd2,  // soft-start duty ramp
    MERS  = 2'd3   // running at full duty
  } stare_t;

  // Direction command encoding
  localparam logic [1:0] DIR_STOP    = 2'b00;
  localparam logic [1:0] DIR_INAINTE = 2'b01;
  localparam logic [1:0] DIR_INAPOI  = 2'b10;

  // Only forward and reverse drive the motor; 00 and 11 both mean stop
  function automatic logic dir_valida(input logic [1:0] d);
    return (d == DIR_INAINTE) || (d == DIR_INAPOI);
  endfunction

endpackage

// File: rtl/driver_motoare_pwm_canal_motor.sv
// One motor channel: command synchronizer, state machine, duty ramp,
// reversal dead time and registered H-bridge pins.
module canal_motor
  import pachet_motoare::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_START  = 64,
  parameter int DUTY_MAX    = 256,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cmd,
  input  logic [PWM_BITS-1:0] cnt_nx,  // counter value after the next edge
  input  logic                wrap,    // next edge starts a new PWM period
  output logic                in1,
  output logic                in2,
  output logic                en,
  output logic                ocupat
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS+1:0] STEP_W    = (PWM_BITS + 2)'(RAMP_STEP);
  localparam logic [PWM_BITS+1:0] START_W   = (PWM_BITS + 2)'(DUTY_START);
  localparam logic [PWM_BITS+1:0] MAX_W     = (PWM_BITS + 2)'(DUTY_MAX);
  localparam logic [PWM_BITS:0]   DUTY_TOP  = MAX_W[PWM_BITS:0];

  // Clamp a widened duty value to the ramp ceiling
  function automatic logic [PWM_BITS:0] sat(input logic [PWM_BITS+1:0] v);
    return (v >= MAX_W) ? DUTY_TOP : v[PWM_BITS:0];
  endfunction

  logic [1:0]          sync1, sync2;
  stare_t              stare, stare_nx;
  logic [1:0]          dir, dir_nx, tinta, tinta_nx;
  logic [PWM_BITS:0]   duty, duty_nx;
  logic [DW-1:0]       mort, mort_nx;
  logic                in1_nx, in2_nx, en_nx, ocupat_nx, run_nx;

  // Two-stage synchronizer for the asynchronous command bits
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= DIR_STOP;
      sync2 <= DIR_STOP;
    end else begin
      sync1 <= cmd;
      sync2 <= sync1;
    end
  end

  // State register together with direction, target, duty and dead counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stare <= FRANA;
      dir   <= DIR_STOP;
      tinta <= DIR_STOP;
      duty  <= '0;
      mort  <= '0;
    end else begin
      stare <= stare_nx;
      dir   <= dir_nx;
      tinta <= tinta_nx;
      duty  <= duty_nx;
      mort  <= mort_nx;
    end
  end

  // Next-state logic: transitions, ramp steps and dead-time countdown
  // NOTE: every variable gets a hold default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    stare_nx = stare;
    dir_nx   = dir;
    tinta_nx = tinta;
    duty_nx  = duty;
    mort_nx  = mort;
    unique case (stare)
      FRANA: begin
        if (dir_valida(sync2)) begin
          stare_nx = RAMPA;
          dir_nx   = sync2;
          duty_nx  = '0;
        end
      end
      RAMPA, MERS: begin
        if (!dir_valida(sync2)) begin
          stare_nx = FRANA;
          duty_nx  = '0;
        end else if (sync2 != dir) begin
          stare_nx = PAUZA;
          tinta_nx = sync2;
          mort_nx  = DEAD_LOAD;
          duty_nx  = '0;
        end else if (stare == RAMPA && wrap) begin
          // First boundary of a ramp loads the start duty, later ones step it
          duty_nx = (duty == '0) ? sat(START_W) : sat({1'b0, duty} + STEP_W);
          if (duty_nx == DUTY_TOP) stare_nx = MERS;
        end
      end
      PAUZA: begin
        if (!dir_valida(sync2)) begin
          stare_nx = FRANA;
          duty_nx  = '0;
        end else begin
          // A new direction mid-pause only retargets; the countdown keeps going
          tinta_nx = sync2;
          if (mort == '0) begin
            stare_nx = RAMPA;
            dir_nx   = sync2;
          end else begin
            mort_nx = mort - 1'b1;
          end
        end
      end
      default: stare_nx = FRANA;
    endcase
  end

  // Pin values derived from next-state values so the pins register with the state
  always_comb begin
    run_nx    = (stare_nx == RAMPA) || (stare_nx == MERS);
    in1_nx    = run_nx && (dir_nx == DIR_INAINTE);
    in2_nx    = run_nx && (dir_nx == DIR_INAPOI);
    en_nx     = run_nx && ({1'b0, cnt_nx} < duty_nx);
    ocupat_nx = (stare_nx == PAUZA) || (stare_nx == RAMPA);
  end

  // Pin registers: glitch-free outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1    <= 1'b0;
      in2    <= 1'b0;
      en     <= 1'b0;
      ocupat <= 1'b0;
    end else begin
      in1    <= in1_nx;
      in2    <= in2_nx;
      en     <= en_nx;
      ocupat <= ocupat_nx;
    end
  end

endmodule

// File: rtl/driver_motoare_pwm.sv
// Dual H-bridge PWM driver: shared free-running PWM counter feeding two
// independent motor channels (A right, B left).
module driver_motoare_pwm
  import pachet_motoare::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_START  = 64,
  parameter int DUTY_MAX    = 256,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] directie_driverA,
  input  logic [1:0] directie_driverB,
  output logic       in1_a,
  output logic       in2_a,
  output logic       en_a,
  output logic       in1_b,
  output logic       in2_b,
  output logic       en_b,
  output logic       ocupat_a,
  output logic       ocupat_b
);

  logic [PWM_BITS-1:0] cnt, cnt_nx;
  logic                wrap;

  assign cnt_nx = cnt + 1'b1;
  assign wrap   = &cnt;

  // Free-running PWM counter, wraps from all-ones back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nx;
  end

  canal_motor #(
    .PWM_BITS(PWM_BITS), .DUTY_START(DUTY_START), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_canal_a (
    .clk(clk), .rst_n(rst_n), .cmd(directie_driverA),
    .cnt_nx(cnt_nx), .wrap(wrap),
    .in1(in1_a), .in2(in2_a), .en(en_a), .ocupat(ocupat_a)
  );

  canal_motor #(
    .PWM_BITS(PWM_BITS), .DUTY_START(DUTY_START), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_canal_b (
    .clk(clk), .rst_n(rst_n), .cmd(directie_driverB),
    .cnt_nx(cnt_nx), .wrap(wrap),
    .in1(in1_b), .in2(in2_b), .en(en_b), .ocupat(ocupat_b)
  );

endmodule

// File: tb/tb_driver_motoare_pwm.sv
// Scoreboard bench for driver_motoare_pwm with a 16-clock PWM period.
// Expected pin vectors {in1,in2,en,ocupat} are queued per channel and cycle
// when a command is driven, and compared at the falling edge of that cycle.
module tb_driver_motoare_pwm;

  localparam int PB  = 4;
  localparam int DS  = 4;
  localparam int DM  = 16;
  localparam int RS  = 4;
  localparam int DC  = 8;
  localparam int PER = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dir_a = 2'b01;
  logic [1:0] dir_b = 2'b01;
  logic       in1_a, in2_a, en_a, in1_b, in2_b, en_b, ocupat_a, ocupat_b;
  logic [3:0] vec_a, vec_b;

  typedef struct {
    int         cyc;
    logic [3:0] exp;
  } item_t;

  item_t sb_a[$];
  item_t sb_b[$];
  int    cyc;
  int    n_checks = 0;
  int    n_pass = 0;

  driver_motoare_pwm #(
    .PWM_BITS(PB), .DUTY_START(DS), .DUTY_MAX(DM),
    .RAMP_STEP(RS), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .directie_driverA(dir_a), .directie_driverB(dir_b),
    .in1_a(in1_a), .in2_a(in2_a), .en_a(en_a),
    .in1_b(in1_b), .in2_b(in2_b), .en_b(en_b),
    .ocupat_a(ocupat_a), .ocupat_b(ocupat_b)
  );

  assign vec_a = {in1_a, in2_a, en_a, ocupat_a};
  assign vec_b = {in1_b, in2_b, en_b, ocupat_b};

  always #5 clk = ~clk;

  // Clock edges since reset release; equals the PWM counter modulo PER
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
  endtask

  // Pins during a ramp that entered RAMPA at clock c0 with direction d
  function automatic logic [3:0] ramp_vec(input int c, input int c0, input logic [1:0] d);
    int k, duty;
    if (c < c0) return 4'b0000;
    k = c / PER - c0 / PER;
    duty = (k == 0) ? 0 : DS + RS * (k - 1);
    if (duty > DM) duty = DM;
    return {d == 2'b01, d == 2'b10, (c % PER) < duty, duty < DM};
  endfunction

  task automatic push(input bit ch, input int c, input logic [3:0] v);
    if (ch == 1'b0) sb_a.push_back(item_t'{c, v});
    else            sb_b.push_back(item_t'{c, v});
  endtask

  task automatic push_ramp(input bit ch, input int from, input int to,
                           input int c0, input logic [1:0] d);
    for (int c = from; c <= to; c++) push(ch, c, ramp_vec(c, c0, d));
  endtask

  task automatic push_const(input bit ch, input int from, input int to, input logic [3:0] v);
    for (int c = from; c <= to; c++) push(ch, c, v);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard pop for channel A
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb_a.size() > 0 && sb_a[0].cyc == cyc) begin
        item_t it;
        it = sb_a.pop_front();
        check("pins_a", vec_a, it.exp);
      end
    end
  end

  // Scoreboard pop for channel B
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb_b.size() > 0 && sb_b[0].cyc == cyc) begin
        item_t it;
        it = sb_b.pop_front();
        check("pins_b", vec_b, it.exp);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both commands already at forward
    repeat (3) @(posedge clk);
    #2;
    check("rst_a", vec_a, 4'b0000);
    check("rst_b", vec_b, 4'b0000);
    push_ramp(1'b0, 1, 74, 3, 2'b01);
    push_ramp(1'b1, 1, 74, 3, 2'b01);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // A reversal from MERS: 8 clocks dead, then reverse ramp; B keeps running
    wait_cyc(72);
    dir_a = 2'b10;
    push_const(1'b0, 75, 82, 4'b0001);
    push_ramp(1'b0, 83, 114, 83, 2'b10);
    push_ramp(1'b1, 75, 150, 3, 2'b01);

    // Stop mid-ramp at duty 8, then restart forward from duty 4
    wait_cyc(112);
    dir_a = 2'b00;
    push_const(1'b0, 115, 122, 4'b0000);
    wait_cyc(120);
    dir_a = 2'b01;
    push_ramp(1'b0, 123, 182, 123, 2'b01);

    // 11 stops like 00
    wait_cyc(180);
    dir_a = 2'b11;
    push_const(1'b0, 183, 188, 4'b0000);
    wait_cyc(186);
    dir_a = 2'b01;
    push_ramp(1'b0, 189, 197, 189, 2'b01);

    // Reversal with the target toggled mid-pause; latest target wins
    wait_cyc(195);
    dir_a = 2'b10;
    push_const(1'b0, 198, 205, 4'b0001);
    push_ramp(1'b0, 206, 232, 206, 2'b01);
    wait_cyc(199);
    dir_a = 2'b01;
    wait_cyc(200);
    dir_a = 2'b10;
    wait_cyc(201);
    dir_a = 2'b01;

    // Both channels stopped, then started together in opposite directions
    wait_cyc(230);
    dir_a = 2'b00;
    dir_b = 2'b00;
    push_const(1'b0, 233, 238, 4'b0000);
    push_ramp(1'b1, 231, 232, 3, 2'b01);
    push_const(1'b1, 233, 238, 4'b0000);
    wait_cyc(236);
    dir_a = 2'b01;
    dir_b = 2'b10;
    push_ramp(1'b0, 239, 252, 239, 2'b01);
    push_ramp(1'b1, 239, 255, 239, 2'b10);

    // Reset pulsed while A is in PAUZA
    wait_cyc(250);
    dir_a = 2'b10;
    push_const(1'b0, 253, 255, 4'b0001);
    wait_cyc(256);
    check("sb_drained", 4'(sb_a.size() + sb_b.size()), 4'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_a", vec_a, 4'b0000);
    check("async_rst_b", vec_b, 4'b0000);
    repeat (2) @(posedge clk);
    push_ramp(1'b0, 1, 20, 3, 2'b10);
    push_ramp(1'b1, 1, 20, 3, 2'b10);
    #2 rst_n = 1'b1;
    wait_cyc(22);

    for (int i = 0; i < 40 && (sb_a.size() + sb_b.size()) > 0; i++) @(negedge clk);
    check("sb_empty", 4'(sb_a.size() + sb_b.size()), 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
